// File: rtl/button_conditioner_pkg.sv
// Shared command-bit indices and frame-word rules for the button front end.
// Imported by the game core as well as by the conditioner itself.
package button_conditioner_pkg;

  localparam int NUM_BUTTONS = 5;
  localparam int NUM_MOVE    = 3;

  localparam int RIGHT  = 0;
  localparam int LEFT   = 1;
  localparam int DOWN   = 2;
  localparam int ROTATE = 3;
  localparam int START  = 4;

  typedef logic [NUM_BUTTONS-1:0] cmd_t;

  // Opposing moves cancel; a frozen game only listens to START.
  function automatic cmd_t frame_word(
    input cmd_t p,
    input logic frz
  );
    cmd_t w;
    w = p;
    if (p[RIGHT] && p[LEFT]) begin
      w[RIGHT] = 1'b0;
      w[LEFT]  = 1'b0;
    end
    if (frz) begin
      w[ROTATE:RIGHT] = '0;
    end
    return w;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button/video-side bundle of the conditioner.
// slave = conditioner, master = board/game side.
interface button_conditioner_if;
  import button_conditioner_pkg::*;

  cmd_t buttons;
  logic vsync;
  logic freeze;
  cmd_t operation;
  cmd_t held;

  modport master (
    output buttons,
    output vsync,
    output freeze,
    input  operation,
    input  held
  );

  modport slave (
    input  buttons,
    input  vsync,
    input  freeze,
    output operation,
    output held
  );

endinterface

// File: rtl/button_conditioner_debouncer.sv
// One-bit synchroniser plus stable-sample counter.
// level flips after DEBOUNCE_CYCLES consecutive differing samples.
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clock,
  input  logic resetn,
  input  logic raw,
  output logic level
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        level <= ~level;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Button front end: debounce, press detect, auto-repeat and
// per-frame command word latched on the synchronised vsync rise.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12,
  parameter int REPEAT_PERIOD   = 4
) (
  input logic                 clock,
  input logic                 resetn,
  button_conditioner_if.slave bus
);

  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] LAST_STEP =
    RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RELOAD =
    RW'(REPEAT_DELAY - REPEAT_PERIOD);

  cmd_t held;
  cmd_t held_q;
  cmd_t rise;
  cmd_t events;
  cmd_t pending;
  cmd_t operation;

  logic [NUM_MOVE-1:0] fall;
  logic [NUM_MOVE-1:0] rep;

  logic [NUM_MOVE-1:0][RW-1:0] rcnt;
  logic [NUM_MOVE-1:0][RW-1:0] rcnt_nx;

  logic vs_meta;
  logic vs_sync;
  logic vs_prev;
  logic frame_edge;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_db
    debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clock (clock),
      .resetn(resetn),
      .raw   (bus.buttons[i]),
      .level (held[i])
    );
  end

  assign rise = held & ~held_q;
  assign fall = ~held[NUM_MOVE-1:0]
              & held_q[NUM_MOVE-1:0];
  assign frame_edge = vs_sync & ~vs_prev;

  // Counter never stores REPEAT_DELAY: hitting it reloads.
  always_comb begin
    rcnt_nx = rcnt;
    rep     = '0;
    for (int k = 0; k < NUM_MOVE; k++) begin
      if (rise[k] || fall[k]) begin
        rcnt_nx[k] = '0;
      end else if (frame_edge && held[k]) begin
        if (rcnt[k] == LAST_STEP) begin
          rcnt_nx[k] = RELOAD;
          rep[k]     = 1'b1;
        end else begin
          rcnt_nx[k] = rcnt[k] + RW'(1);
        end
      end
    end
  end

  assign events = rise
    | {{(NUM_BUTTONS-NUM_MOVE){1'b0}}, rep};

  // Same-cycle events land in the freshly cleared pending.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      vs_meta   <= 1'b0;
      vs_sync   <= 1'b0;
      vs_prev   <= 1'b0;
      held_q    <= '0;
      rcnt      <= '0;
      pending   <= '0;
      operation <= '0;
    end else begin
      vs_meta <= bus.vsync;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
      held_q  <= held;
      rcnt    <= rcnt_nx;
      if (frame_edge) begin
        operation <= frame_word(pending, bus.freeze);
        pending   <= events;
      end else begin
        pending <= pending | events;
      end
    end
  end

  assign bus.operation = operation;
  assign bus.held      = held;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with a frame-level
// reference model and directed test-plan scenarios.
module tb_button_conditioner;
  import button_conditioner_pkg::*;

  localparam int DB   = 4;
  localparam int RD   = 3;
  localparam int RP   = 2;
  localparam int VPER = 40;
  localparam int VPW  = 6;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  button_conditioner_if ifc();

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (ifc)
  );

  int vcnt = 0;
  always @(negedge clock)
    vcnt <= (vcnt == VPER - 1) ? 0 : vcnt + 1;
  assign ifc.vsync = (vcnt < VPW);

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h",
               name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    cmd_t op;
    cmd_t held;
    bit   fe;
  } exp_t;

  exp_t sbq[$];
  cmd_t rawq[$];
  logic [3:0] vh;
  cmd_t m_h, m_hp, m_pend, m_op;
  int   nfr[3];

  function automatic cmd_t ref_word(cmd_t p, logic frz);
    cmd_t w;
    w = p;
    if (frz) w = w & 5'b10000;
    else if (p[0] && p[1]) w = w & 5'b11100;
    return w;
  endfunction

  always @(posedge clock) begin : model
    exp_t e;
    cmd_t flip, rise, fall, ev;
    bit fe, all;
    if (!resetn) begin
      rawq.delete();
      for (int j = 0; j < DB + 2; j++) rawq.push_back('0);
      vh = '0; m_h = '0; m_hp = '0;
      m_pend = '0; m_op = '0;
      for (int b = 0; b < 3; b++) nfr[b] = 0;
      fe = 1'b0;
    end else begin
      rawq.push_back(ifc.buttons);
      if (rawq.size() > DB + 2) void'(rawq.pop_front());
      // level flips once the last DB synced samples all disagree
      flip = '0;
      for (int b = 0; b < 5; b++) begin
        all = 1'b1;
        for (int j = 0; j < DB; j++)
          if (rawq[j][b] == m_h[b]) all = 1'b0;
        flip[b] = all;
      end
      vh = {vh[2:0], ifc.vsync};
      fe = vh[2] & ~vh[3];
      rise = m_h & ~m_hp;
      fall = ~m_h & m_hp;
      ev = rise;
      for (int b = 0; b < 3; b++) begin
        if (rise[b] || fall[b]) nfr[b] = 0;
        else if (fe && m_h[b]) begin
          nfr[b]++;
          if (nfr[b] >= RD && (nfr[b] - RD) % RP == 0)
            ev[b] = 1'b1;
        end
      end
      if (fe) begin
        m_op = ref_word(m_pend, ifc.freeze);
        m_pend = ev;
      end else begin
        m_pend = m_pend | ev;
      end
      m_hp = m_h;
      m_h = m_h ^ flip;
    end
    e.op = m_op;
    e.held = m_h;
    e.fe = fe;
    sbq.push_back(e);
  end

  // ---------------- monitor ----------------
  cmd_t dut_frames[$];
  int loads = 0;

  always @(negedge clock) begin : monitor
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("operation", ifc.operation, e.op);
      chk("held", ifc.held, e.held);
      if (e.fe) begin
        dut_frames.push_back(ifc.operation);
        loads++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_loads(int n);
    int target;
    int budget;
    target = loads + n;
    budget = (n + 2) * VPER;
    while (loads < target && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    if (loads < target) chk("frame_timeout", loads, target);
  endtask

  task automatic frame_start();
    wait_loads(1);
    cyc(2);
    dut_frames.delete();
  endtask

  task automatic settle();
    ifc.buttons = '0;
    ifc.freeze = 1'b0;
    wait_loads(2);
  endtask

  function automatic int nonzero_frames();
    int n = 0;
    foreach (dut_frames[i]) if (dut_frames[i] != '0) n++;
    return n;
  endfunction

  function automatic cmd_t or_frames();
    cmd_t w = '0;
    foreach (dut_frames[i]) w = w | dut_frames[i];
    return w;
  endfunction

  initial begin : stim
    logic [13:0] vec;
    cmd_t b;
    int len;
    ifc.buttons = '0;
    ifc.freeze = 1'b0;
    resetn = 1'b0;
    cyc(3);
    chk("reset_operation", ifc.operation, 0);
    chk("reset_held", ifc.held, 0);
    resetn = 1'b1;
    wait_loads(2);

    // bounce rejection
    frame_start();
    for (int i = 0; i < 10; i++) begin
      ifc.buttons[ROTATE] = ~ifc.buttons[ROTATE];
      cyc(2);
    end
    ifc.buttons[ROTATE] = 1'b1;
    wait_loads(3);
    chk("bounce_count", nonzero_frames(), 1);
    chk("bounce_word", or_frames(), 5'b01000);
    chk("bounce_first", dut_frames[0], 5'b01000);
    settle();

    // auto-repeat
    frame_start();
    ifc.buttons[LEFT] = 1'b1;
    wait_loads(10);
    cyc(2);
    ifc.buttons[LEFT] = 1'b0;
    wait_loads(4);
    chk("repeat_nframes", dut_frames.size(), 14);
    vec = '0;
    foreach (dut_frames[i])
      if (i < 14) vec[i] = dut_frames[i][LEFT];
    chk("repeat_frames", vec, 14'h2A9);
    chk("repeat_other", or_frames() & 5'b11101, 0);
    settle();

    // conflict, without and with DOWN
    for (int p = 0; p < 2; p++) begin
      frame_start();
      ifc.buttons[RIGHT] = 1'b1;
      if (p == 1) ifc.buttons[DOWN] = 1'b1;
      cyc($urandom_range(0, 15));
      ifc.buttons[LEFT] = 1'b1;
      wait_loads(1);
      cyc(2);
      chk(p == 0 ? "conflict" : "conflict_down",
          dut_frames[0], p == 0 ? 5'b00000 : 5'b00100);
      settle();
    end

    // freeze
    frame_start();
    ifc.freeze = 1'b1;
    ifc.buttons = 5'b10100;
    wait_loads(1);
    cyc(2);
    chk("freeze", dut_frames[0], 5'b10000);
    settle();

    // held rise on the frame-edge cycle
    wait_loads(1);
    do @(negedge clock); while (vcnt != VPER - 5);
    dut_frames.delete();
    ifc.buttons[ROTATE] = 1'b1;
    wait_loads(2);
    chk("collision_now", dut_frames[0], 5'b00000);
    chk("collision_next", dut_frames[1], 5'b01000);
    settle();

    // reset mid-repeat
    frame_start();
    ifc.buttons[LEFT] = 1'b1;
    wait_loads(5);
    cyc(7);
    resetn = 1'b0;
    cyc(1);
    resetn = 1'b1;
    chk("rst_operation", ifc.operation, 0);
    chk("rst_held", ifc.held, 0);
    cyc(DB + 1);
    chk("rst_held_early", ifc.held[LEFT], 0);
    cyc(1);
    chk("rst_held_back", ifc.held[LEFT], 1);
    dut_frames.delete();
    wait_loads(1);
    chk("rst_fresh_press", dut_frames[0], 5'b00010);
    settle();

    // randomized traffic with glitches, freeze and resets
    for (int s = 0; s < 120; s++) begin
      b = cmd_t'($urandom);
      len = $urandom_range(1, 30);
      ifc.freeze = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 39) == 0) begin
        resetn = 1'b0;
        cyc(1);
        resetn = 1'b1;
      end
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 7) == 0)
          ifc.buttons = ifc.buttons ^ cmd_t'($urandom);
        else
          ifc.buttons = b;
        cyc(1);
      end
    end
    settle();
    cyc(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
